// File: rtl/ber_stat_reader.sv
// Snapshots the PRBS checker bit/error counters and streams them as a tagged frame; BER_STAT_CHECKSUM_EN appends an XOR word.
// Valid rises in the second cycle after the request cycle; words hold steady while out_ready is low; one request queues while busy.
module ber_stat_reader #(
    parameter logic [15:0] HEADER_TAG = 16'hBE5A,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] total_bits,
    input  logic [CNT_W-1:0] total_bit_errors,
    input  logic             snap_req,
    output logic [CNT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       dropped_req
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

`ifdef BER_STAT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif
    localparam logic [7:0] FRAME_LEN = {5'd0, LAST_IDX} + 8'd1;

    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic [7:0]       r_seq;
    logic             r_pending;
    logic [7:0]       r_dropped;
    logic [CNT_W-1:0] r_snap_bits;
    logic [CNT_W-1:0] r_snap_err;
    logic [CNT_W-1:0] r_prev_bits;
    logic [CNT_W-1:0] r_prev_err;
    logic [CNT_W-1:0] r_delta_bits;
    logic [CNT_W-1:0] r_delta_err;

    logic [CNT_W-1:0] w_word0;
    logic [CNT_W-1:0] w_word;
    logic             w_send;
    logic             w_accept;

    assign w_word0  = {HEADER_TAG, r_seq, FRAME_LEN};
    assign w_send   = (r_state == SEND);
    assign w_accept = w_send & out_ready;

    always_comb begin
        w_word = '0;
        case (r_idx)
            3'd0:    w_word = w_word0;
            3'd1:    w_word = r_snap_bits;
            3'd2:    w_word = r_snap_err;
            3'd3:    w_word = r_delta_bits;
            3'd4:    w_word = r_delta_err;
`ifdef BER_STAT_CHECKSUM_EN
            3'd5:    w_word = w_word0 ^ r_snap_bits ^ r_snap_err ^ r_delta_bits ^ r_delta_err;
`endif
            default: w_word = '0;
        endcase
    end

    // Outputs decode directly from state so reset clears them without waiting for a clock.
    assign out_valid   = w_send;
    assign out_data    = w_send ? w_word : '0;
    assign out_last    = w_send && (r_idx == LAST_IDX);
    assign busy        = (r_state != IDLE);
    assign dropped_req = r_dropped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_seq        <= '0;
            r_pending    <= 1'b0;
            r_dropped    <= '0;
            r_snap_bits  <= '0;
            r_snap_err   <= '0;
            r_prev_bits  <= '0;
            r_prev_err   <= '0;
            r_delta_bits <= '0;
            r_delta_err  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (snap_req || r_pending) begin
                        r_snap_bits <= total_bits;
                        r_snap_err  <= total_bit_errors;
                        r_pending   <= 1'b0;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Modular subtraction absorbs a counter wrap between snapshots.
                    r_delta_bits <= r_snap_bits - r_prev_bits;
                    r_delta_err  <= r_snap_err - r_prev_err;
                    r_prev_bits  <= r_snap_bits;
                    r_prev_err   <= r_snap_err;
                    r_idx        <= '0;
                    r_state      <= SEND;
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_seq   <= r_seq + 8'd1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (busy && snap_req) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_dropped != 8'hFF) begin
                    r_dropped <= r_dropped + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ber_stat_reader.sv
// Directed bench for ber_stat_reader: frame contents, latency, wrap, backpressure, request queueing and reset.
module tb_ber_stat_reader;

`ifdef BER_STAT_CHECKSUM_EN
    localparam int NW = 6;
`else
    localparam int NW = 5;
`endif
    localparam logic [7:0] LEN = 8'(NW);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] total_bits = '0;
    logic [31:0] total_bit_errors = '0;
    logic        snap_req = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic [7:0]  dropped_req;

    int total = 0;
    int bad = 0;

    logic [31:0] fr_w [0:5];
    int          fr_n;
    bit          fr_ok;

    ber_stat_reader dut (
        .clk              (clk),
        .rst              (rst),
        .total_bits       (total_bits),
        .total_bit_errors (total_bit_errors),
        .snap_req         (snap_req),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .dropped_req      (dropped_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hdr(input logic [7:0] s);
        return {16'hBE5A, s, LEN};
    endfunction

    // One-cycle request; returns at the falling edge after the sampling edge.
    task automatic snap(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        total_bits       = b;
        total_bit_errors = e;
        snap_req         = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Records words until the last one is accepted, bounded in cycles.
    task automatic collect();
        fr_n      = 0;
        fr_ok     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) fr_w[i] = 32'hDEAD_BEEF;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (fr_n < 6) fr_w[fr_n] = out_data;
                fr_n++;
                if (out_last) begin
                    fr_ok = 1'b1;
                    @(negedge clk);
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || dropped_req !== 8'h0) begin
            bad++;
            $display("FAIL reset_state got valid=%b last=%b busy=%b data=%h drop=%h want all zero",
                     out_valid, out_last, busy, out_data, dropped_req);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_first_frame();
        logic [31:0] exp [0:5];
        snap(32'd1000, 32'd3);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_cycle got valid=%b busy=%b want 0 1", out_valid, busy);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL valid_latency got %b want 1", out_valid);
        end
        collect();
        exp = '{hdr(8'd0), 32'h3E8, 32'h3, 32'h3E8, 32'h3, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        total++;
        if (!fr_ok || fr_n !== NW) begin
            bad++;
            $display("FAIL first_len got n=%0d last_seen=%0d want n=%0d", fr_n, fr_ok, NW);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL first_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
    endtask

    task automatic test_second_frame();
        logic [31:0] exp [0:5];
        snap(32'd1500, 32'd5);
        collect();
        exp = '{hdr(8'd1), 32'd1500, 32'd5, 32'd500, 32'd2, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        total++;
        if (!fr_ok || fr_n !== NW) begin
            bad++;
            $display("FAIL second_len got n=%0d want %0d", fr_n, NW);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL second_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [0:5];
        snap(32'hFFFF_FF00, 32'd10);
        collect();
        snap(32'h0000_0100, 32'd12);
        collect();
        exp = '{hdr(8'd3), 32'h100, 32'd12, 32'h200, 32'd2, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        total++;
        if (!fr_ok || fr_n !== NW) begin
            bad++;
            $display("FAIL wrap_len got n=%0d want %0d", fr_n, NW);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL wrap_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [0:5];
        exp = '{hdr(8'd4), 32'h300, 32'h3, 32'h200, 32'hFFFF_FFF7, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        out_ready = 1'b1;
        snap(32'h300, 32'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h3 || out_last !== 1'b0) begin
                bad++;
                $display("FAIL hold_c%0d got valid=%b data=%h last=%b want 1 00000003 0",
                         c, out_valid, out_data, out_last);
            end
            @(negedge clk);
        end
        collect();
        total++;
        if (!fr_ok || fr_n !== NW - 2) begin
            bad++;
            $display("FAIL bp_len got n=%0d want %0d", fr_n, NW - 2);
        end
        for (int i = 2; i < NW; i++) begin
            total++;
            if (fr_w[i-2] !== exp[i]) begin
                bad++;
                $display("FAIL bp_w%0d got %h want %h", i, fr_w[i-2], exp[i]);
            end
        end
    endtask

    task automatic test_pending_drop();
        logic [31:0] exp [0:5];
        snap(32'd5000, 32'd20);
        @(negedge clk);
        out_ready        = 1'b0;
        total_bits       = 32'd7000;
        total_bit_errors = 32'd30;
        for (int p = 0; p < 3; p++) begin
            snap_req = 1'b1;
            @(negedge clk);
            snap_req = 1'b0;
            @(negedge clk);
        end
        total_bits       = 32'd6000;
        total_bit_errors = 32'd25;
        total++;
        if (dropped_req !== 8'd2) begin
            bad++;
            $display("FAIL drop_count got %0d want 2", dropped_req);
        end
        collect();
        exp = '{hdr(8'd5), 32'd5000, 32'd20, 32'd4232, 32'd17, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL held_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
        collect();
        exp = '{hdr(8'd6), 32'd6000, 32'd25, 32'd1000, 32'd5, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        total++;
        if (!fr_ok || fr_n !== NW) begin
            bad++;
            $display("FAIL pend_len got n=%0d want %0d", fr_n, NW);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL pend_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
    endtask

    task automatic test_last_edge_req();
        bit seen;
        seen = 1'b0;
        snap(32'd6500, 32'd26);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_last) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL lastedge_timeout got no out_last want out_last");
        end
        total_bits       = 32'd6600;
        total_bit_errors = 32'd27;
        snap_req         = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        total++;
        if (dropped_req !== 8'd2) begin
            bad++;
            $display("FAIL lastedge_drop got %0d want 2", dropped_req);
        end
        collect();
        total++;
        if (!fr_ok || fr_w[0] !== hdr(8'd8) || fr_w[1] !== 32'd6600 || fr_w[3] !== 32'd100) begin
            bad++;
            $display("FAIL lastedge_frame got w0=%h w1=%h w3=%h want %h 000019c8 00000064",
                     fr_w[0], fr_w[1], fr_w[3], hdr(8'd8));
        end
    endtask

    task automatic test_saturate();
        snap(32'd8000, 32'd40);
        @(negedge clk);
        out_ready = 1'b0;
        snap_req  = 1'b1;
        repeat (300) @(negedge clk);
        snap_req = 1'b0;
        total++;
        if (dropped_req !== 8'hFF) begin
            bad++;
            $display("FAIL drop_sat got %h want ff", dropped_req);
        end
        collect();
        total++;
        if (!fr_ok || fr_w[0] !== hdr(8'd9) || fr_w[3] !== 32'd1400 || fr_w[4] !== 32'd13) begin
            bad++;
            $display("FAIL sat_frame got w0=%h w3=%h w4=%h want %h 00000578 0000000d",
                     fr_w[0], fr_w[3], fr_w[4], hdr(8'd9));
        end
        collect();
        total++;
        if (!fr_ok || fr_w[0] !== hdr(8'd10) || fr_w[3] !== 32'd0 || dropped_req !== 8'hFF) begin
            bad++;
            $display("FAIL sat_pending got w0=%h w3=%h drop=%h want %h 00000000 ff",
                     fr_w[0], fr_w[3], dropped_req, hdr(8'd10));
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] exp [0:5];
        snap(32'd777, 32'd7);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL midframe_pos got valid=%b last=%b want 1 0", out_valid, out_last);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || dropped_req !== 8'h0) begin
            bad++;
            $display("FAIL async_reset got valid=%b last=%b busy=%b data=%h drop=%h want all zero",
                     out_valid, out_last, busy, out_data, dropped_req);
        end
        @(negedge clk);
        rst = 1'b0;
        snap(32'd100, 32'd1);
        collect();
        exp = '{hdr(8'd0), 32'd100, 32'd1, 32'd100, 32'd1, 32'h0};
        exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
        total++;
        if (!fr_ok || fr_n !== NW) begin
            bad++;
            $display("FAIL post_reset_len got n=%0d want %0d", fr_n, NW);
        end
        for (int i = 0; i < NW; i++) begin
            total++;
            if (fr_w[i] !== exp[i]) begin
                bad++;
                $display("FAIL post_reset_w%0d got %h want %h", i, fr_w[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_wrap();
        test_backpressure();
        test_pending_drop();
        test_last_edge_req();
        test_saturate();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
